// File: rtl/linebuf_pkg.sv
// Shared OCP command/response codes and FSM states for the line_buffer read path.
package linebuf_pkg;

    localparam int LINE_LEN_DEFAULT = 160;

    typedef enum logic [2:0] {
        MCMD_IDLE = 3'b000,
        MCMD_WR   = 3'b001,
        MCMD_RD   = 3'b010
    } mcmd_t;

    typedef enum logic [1:0] {
        SRESP_NULL = 2'b00,
        SRESP_DVA  = 2'b01,
        SRESP_ERR  = 2'b11
    } sresp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_RESP,
        ST_DONE
    } state_t;

    // The reserved code 2'b10 counts as no response.
    function automatic logic resp_present(input logic [1:0] resp);
        return (resp == SRESP_DVA) || (resp == SRESP_ERR);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with registered head; no fall-through, count output.
module byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL_COUNT) || w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/linebuf_reader.sv
// OCP read master that walks one stored line byte by byte into a valid/ready
// stream, reporting a 16-bit checksum and a sticky error flag per line.
module linebuf_reader
    import linebuf_pkg::*;
#(
    parameter int LINE_LEN   = LINE_LEN_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        readClk,
    input  logic        readRst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] line_sum,
    output logic        err,
    output logic [2:0]  linebuf_MCmd,
    output logic [7:0]  linebuf_MAddr,
    output logic [7:0]  linebuf_MData,
    input  logic        linebuf_SCmdAccept,
    input  logic [7:0]  linebuf_SData,
    input  logic [1:0]  linebuf_SResp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [8:0] LAST_ADDR = 9'(LINE_LEN - 1);

    state_t      r_state, w_state_next;
    logic [8:0]  r_addr, w_addr_next;
    logic [15:0] r_sum, w_sum_next;
    logic        r_err, w_err_next;
    logic [2:0]  r_mcmd, w_mcmd_next;
    logic        r_busy, w_busy_next;
    logic        r_done, w_done_next;
    logic        r_cap_valid, w_cap_valid_next;
    logic        r_cap_err, w_cap_err_next;
    logic [7:0]  r_cap_data, w_cap_data_next;

    logic             w_resp_hit;
    logic             w_resp_err;
    logic [7:0]       w_resp_data;
    logic             w_push;
    logic [8:0]       w_push_entry;
    logic             w_pop;
    logic [CNT_W-1:0] w_fifo_count;
    logic [CNT_W-1:0] w_count_after;
    logic [8:0]       w_fifo_head;

    // A response captured alongside the accept takes priority over the live bus.
    assign w_resp_hit  = r_cap_valid || resp_present(linebuf_SResp);
    assign w_resp_err  = r_cap_valid ? r_cap_err  : (linebuf_SResp == SRESP_ERR);
    assign w_resp_data = r_cap_valid ? r_cap_data : linebuf_SData;

    assign out_valid = (w_fifo_count != '0);
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_state_next     = r_state;
        w_addr_next      = r_addr;
        w_sum_next       = r_sum;
        w_err_next       = r_err;
        w_cap_valid_next = r_cap_valid;
        w_cap_err_next   = r_cap_err;
        w_cap_data_next  = r_cap_data;
        w_push           = 1'b0;
        w_push_entry     = '0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_err_next   = 1'b0;
                    w_sum_next   = '0;
                    w_addr_next  = '0;
                    w_state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if ((r_mcmd == MCMD_RD) && linebuf_SCmdAccept) begin
                    w_cap_valid_next = resp_present(linebuf_SResp);
                    w_cap_err_next   = (linebuf_SResp == SRESP_ERR);
                    w_cap_data_next  = linebuf_SData;
                    w_state_next     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_resp_hit) begin
                    w_push           = 1'b1;
                    w_push_entry     = {(r_addr == LAST_ADDR), (w_resp_err ? 8'h00 : w_resp_data)};
                    w_cap_valid_next = 1'b0;
                    if (w_resp_err) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_sum_next = r_sum + {8'h00, w_resp_data};
                    end
                    if (r_addr == LAST_ADDR) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_addr_next  = r_addr + 9'd1;
                        w_state_next = ST_CMD;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Registered outputs look one step ahead; the free-slot test uses the
        // occupancy after this edge so a read is only issued with space reserved.
        w_count_after = w_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_busy_next   = (w_state_next != ST_IDLE);
        w_done_next   = (w_state_next == ST_DONE);
        w_mcmd_next   = ((w_state_next == ST_CMD) && (w_count_after < DEPTH_COUNT)) ? MCMD_RD : MCMD_IDLE;
    end

    always_ff @(posedge readClk or posedge readRst) begin
        if (readRst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_sum       <= '0;
            r_err       <= 1'b0;
            r_mcmd      <= MCMD_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cap_valid <= 1'b0;
            r_cap_err   <= 1'b0;
            r_cap_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_addr      <= w_addr_next;
            r_sum       <= w_sum_next;
            r_err       <= w_err_next;
            r_mcmd      <= w_mcmd_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_cap_valid <= w_cap_valid_next;
            r_cap_err   <= w_cap_err_next;
            r_cap_data  <= w_cap_data_next;
        end
    end

    byte_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (readClk),
        .i_rst   (readRst),
        .i_push  (w_push),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_head),
        .o_count (w_fifo_count)
    );

    assign busy          = r_busy;
    assign done          = r_done;
    assign line_sum      = r_sum;
    assign err           = r_err;
    assign linebuf_MCmd  = r_mcmd;
    assign linebuf_MAddr = r_addr[7:0];
    assign linebuf_MData = 8'h00;
    assign out_data      = w_fifo_head[7:0];
    assign out_last      = w_fifo_head[8];

endmodule
